// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the muldiv divider slice.
package muldiv_pkg;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Two's complement negate; callers zero-extend in and truncate out to their width.
  function automatic logic [63:0] twos_neg(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module muldiv_lzc #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic [WIDTH-1:0] value,
  output logic [CNT_W-1:0] lz
);

  // Scan upward so the highest set bit determines the count.
  always_comb begin
    lz = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) lz = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/muldiv_div_core.sv
// Iterative radix-2 restoring divider (RV32M DIV/DIVU/REM/REMU semantics).
// Define DIV_EARLY_TERM_EN to skip leading-zero dividend iterations.
module muldiv_div_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             op_div1,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             div_busy,
  output logic             div_rdy,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem,
  output logic [WIDTH-1:0] div_result
);

  div_state_t       state;
  logic             arm;
  logic             op_rem;
  logic             neg_a;
  logic             neg_b;
  logic             zb;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] bmag;
  logic [CNT_W-1:0] count;

  logic             neg_a_c;
  logic             neg_b_c;
  logic [WIDTH-1:0] amag_c;
  logic [WIDTH-1:0] bmag_c;
  logic [WIDTH:0]   sub_c;
  logic [WIDTH:0]   diff_c;
  logic             take_c;
  logic [WIDTH-1:0] rem_next_c;
  logic [WIDTH-1:0] quot_c;
  logic [WIDTH-1:0] rem_c;

`ifdef DIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lz_c;

  muldiv_lzc #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_lzc (
    .value(amag_c),
    .lz   (lz_c)
  );
`endif

  // Operand magnitudes, one restoring step, and sign fix-up of the final result.
  always_comb begin
    neg_a_c    = div_signed & A[WIDTH-1];
    neg_b_c    = div_signed & B[WIDTH-1];
    amag_c     = neg_a_c ? WIDTH'(twos_neg(64'(A))) : A;
    bmag_c     = neg_b_c ? WIDTH'(twos_neg(64'(B))) : B;
    sub_c      = {rem_acc, dvd_q[WIDTH-1]};
    take_c     = (sub_c >= {1'b0, bmag});
    diff_c     = sub_c - {1'b0, bmag};
    rem_next_c = take_c ? WIDTH'(diff_c) : WIDTH'(sub_c);
    quot_c     = zb ? '1 : ((neg_a ^ neg_b) ? WIDTH'(twos_neg(64'(dvd_q))) : dvd_q);
    rem_c      = neg_a ? WIDTH'(twos_neg(64'(rem_acc))) : rem_acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      arm        <= 1'b0;
      op_rem     <= 1'b0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      zb         <= 1'b0;
      dvd_q      <= '0;
      rem_acc    <= '0;
      bmag       <= '0;
      count      <= '0;
      div_busy   <= 1'b0;
      div_rdy    <= 1'b0;
      div_quot   <= '0;
      div_rem    <= '0;
      div_result <= '0;
    end else begin
      div_rdy <= 1'b0;
      // A start level held past div_rdy must drop once before it can launch again.
      if (!div_start) arm <= 1'b1;
      case (state)
        IDLE: begin
          if (div_start && arm) begin
            arm      <= 1'b0;
            op_rem   <= op_div1;
            neg_a    <= neg_a_c;
            neg_b    <= neg_b_c;
            zb       <= (B == '0);
            bmag     <= bmag_c;
            rem_acc  <= '0;
            div_busy <= 1'b1;
`ifdef DIV_EARLY_TERM_EN
            dvd_q    <= amag_c << lz_c;
            count    <= lz_c;
            state    <= (amag_c == '0) ? FIX : CALC;
`else
            dvd_q    <= amag_c;
            count    <= '0;
            state    <= CALC;
`endif
          end
        end
        CALC: begin
          rem_acc <= rem_next_c;
          dvd_q   <= {dvd_q[WIDTH-2:0], take_c};
          count   <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          div_quot   <= quot_c;
          div_rem    <= rem_c;
          div_result <= op_rem ? rem_c : quot_c;
          state      <= DONE;
        end
        DONE: begin
          div_rdy  <= 1'b1;
          div_busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_div_core.sv
// Scoreboard bench for muldiv_div_core: directed vectors, decoupled monitor on div_rdy.
module tb_muldiv_div_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_start;
  logic        div_signed;
  logic        op_div1;
  logic [31:0] A;
  logic [31:0] B;
  logic        div_busy;
  logic        div_rdy;
  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic [31:0] div_result;

  typedef struct {
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] result;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  muldiv_div_core dut (
    .clk       (clk),
    .reset     (reset),
    .div_start (div_start),
    .div_signed(div_signed),
    .op_div1   (op_div1),
    .A         (A),
    .B         (B),
    .div_busy  (div_busy),
    .div_rdy   (div_rdy),
    .div_quot  (div_quot),
    .div_rem   (div_rem),
    .div_result(div_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic s);
`ifdef DIV_EARLY_TERM_EN
    logic [31:0] m;
    int lz;
    m  = (s && a[31]) ? (~a + 32'd1) : a;
    lz = 32;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) begin
        lz = 31 - i;
        break;
      end
    end
    return 32 - lz + 2;
`else
    return 34;
`endif
  endfunction

  // Monitor: every div_rdy pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (div_rdy) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got div_rdy=1 expected no pending request");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("quot", div_quot, e.quot);
        check("rem", div_rem, e.rem);
        check("result", div_result, e.result);
        check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s, input logic op);
    @(negedge clk);
    A          = a;
    B          = b;
    div_signed = s;
    op_div1    = op;
    div_start  = 1'b1;
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input logic op,
                         input logic [31:0] q, input logic [31:0] r, input int hold);
    exp_t e;
    bit   seen;
    launch(a, b, s, op);
    e.quot    = q;
    e.rem     = r;
    e.result  = op ? r : q;
    e.acc_cyc = cyc + 1;
    e.lat     = exp_lat(a, s);
    sb_q.push_back(e);
    @(negedge clk);
    check("busy_after_accept", 32'(div_busy), 32'd1);
    seen = div_rdy;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = div_rdy;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL rdy_timeout: got no div_rdy expected one within 200 cycles");
      void'(sb_q.pop_front());
    end
    // Holding start after completion must not relaunch.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_no_busy", 32'(div_busy), 32'd0);
    end
    div_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    op_div1    = 1'b0;
    A          = '0;
    B          = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(div_busy), 32'd0);
    check("reset_rdy", 32'(div_rdy), 32'd0);
    check("reset_quot", div_quot, 32'd0);
    check("reset_rem", div_rem, 32'd0);
    check("reset_result", div_result, 32'd0);
    reset = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 0);
    run_div(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, 0);
    run_div(32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);
    run_div(32'd100, 32'hFFFFFFF9, 1'b1, 1'b1, 32'hFFFFFFF2, 32'd2, 0);
    run_div(32'h1234, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h1234, 0);
    run_div(32'h1234, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h1234, 0);
    run_div(32'hFFFFEDCC, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFEDCC, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 32'd0, 0);
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, 32'h80000000, 0);
    run_div(32'd5, 32'd9, 1'b0, 1'b1, 32'd0, 32'd5, 0);
    run_div(32'hFFFFFFFB, 32'd9, 1'b1, 1'b1, 32'd0, 32'hFFFFFFFB, 0);
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd0, 0);
    run_div(32'd7, 32'd2, 1'b0, 1'b0, 32'd3, 32'd1, 0);
    run_div(32'd0, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, 0);

    // Start held high after completion, then dropped for one cycle and raised again.
    run_div(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 5);
    run_div(32'd1000, 32'd10, 1'b0, 1'b1, 32'd100, 32'd0, 0);

    // Reset in the middle of CALC aborts with no visible result.
    launch(32'd500, 32'd3, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(div_busy), 32'd0);
    check("abort_rdy", 32'(div_rdy), 32'd0);
    check("abort_quot", div_quot, 32'd0);
    check("abort_rem", div_rem, 32'd0);
    check("abort_result", div_result, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    div_start = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_rdy_pending", 32'(sb_q.size()), 32'd0);
    run_div(32'd500, 32'd3, 1'b0, 1'b1, 32'd166, 32'd2, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
